bist_march_ctrl: RTL and testbench
==================================

Name: bist_march_ctrl

Overview:
- Sequencer for the SRAM built-in self-test.
- For each background pattern it writes every address, then reads every address back and compares each word against the expected pattern.
- Drives the SRAM port directly, owns the address counter and pattern-select state, and reports pass/fail plus first-failure diagnostics to the test host.

Parameters:
ADDR_W, 10, SRAM address width; depth = 2^ADDR_W words.
NUM_PAT, 6, number of patterns run (legal range 1..8); patterns are indexed 0..NUM_PAT-1.

Ports:
clk  input  1  clock; all logic rises on posedge.
rst  input  1  synchronous, active-high reset.
start  input  1  level; sampled only in IDLE or DONE.
busy  output  1  high in WRITE/READ/DRAIN.
done  output  1  high in DONE.
fail  output  1  sticky mismatch flag.
fail_addr  output  ADDR_W  address of the first mismatch.
fail_pat  output  3  pattern index of the first mismatch.
fail_data  output  8  read data at the first mismatch.
mem_ce  output  1  SRAM chip enable.
mem_we  output  1  SRAM write enable (1 = write).
mem_addr  output  ADDR_W  SRAM address.
mem_wdata  output  8  SRAM write data.
mem_rdata  input  8  SRAM read data; valid the cycle after a read is issued.

Behaviour:
- Reset: rst forces the IDLE state. All outputs go to 0 and the pattern index goes to 0; this applies at any time, including mid-run.
- Pattern table (8 bits per index): 0=0xAA, 1=0x55, 2=0xF0, 3=0x0F, 4=0x00, 5=0xFF, 6=0x00, 7=0xFF.
- Cycle numbering: cycle 0 is the cycle in which start is sampled high.
- IDLE/DONE + start:
  - clear fail and all fail_* outputs;
  - set pattern index p=0 and address=0;
  - go to WRITE in cycle 1.
- WRITE:
  - outputs: mem_ce=1, mem_we=1, mem_addr=addr, mem_wdata=pattern[p];
  - addr increments each cycle;
  - when addr==2^ADDR_W-1: wrap addr to 0 and go to READ.
- READ:
  - outputs: mem_ce=1, mem_we=0, mem_wdata=0;
  - addr increments each cycle;
  - when addr==2^ADDR_W-1: go to DRAIN.
- DRAIN:
  - one cycle, mem_ce=0; the last read is compared here;
  - if p==NUM_PAT-1, go to DONE;
  - otherwise p++, addr=0, go to WRITE.
- Timing: each pattern takes 2*2^ADDR_W+1 cycles. Pattern p starts WRITE in cycle 1+p*(2*2^ADDR_W+1). done rises the cycle after the final DRAIN.
- Compare pipeline:
  - a read issued in cycle N with address A is compared in cycle N+1 (mem_rdata vs pattern[p]);
  - on mismatch, fail=1 is visible from cycle N+2;
  - only the first mismatch loads fail_addr=A, fail_pat=p, fail_data=mem_rdata;
  - later mismatches leave fail and all fail_* outputs unchanged.
- start while busy is ignored. start held high in DONE restarts the run immediately.
- done stays high and fail/fail_* hold their values until the next start or rst.
- mem_ce=0 and mem_we=0 in IDLE, DRAIN and DONE.

Optional Feature:
BIST_STOP_ON_FAIL_EN
- Defined: the cycle that sets fail also moves the state to DONE, so done=1 and fail=1 appear together.
  - The read issued in the compare cycle (one extra) is discarded.
  - mem_ce=0 from the DONE cycle onward.
- Undefined: a mismatch never changes the sequence; the run always completes all NUM_PAT patterns.

Test Plan:
1. Reset check: rst=1 for 2 cycles -> all outputs 0; start=0 for 10 cycles -> still idle, mem_ce=0.
2. Clean run, ADDR_W=4, NUM_PAT=6, ideal SRAM model, start in cycle 0:
   - mem_wdata=0xAA for addr 0..15 in cycles 1..16;
   - reads in cycles 17..32; WRITE of 0x55 starts in cycle 34;
   - done=1 from cycle 199, fail=0.
3. Stuck-at-0 on bit 0 at addr 5, same setup, macro off:
   - pattern 1 read of addr 5 is issued in cycle 55;
   - fail=1 from cycle 57 with fail_addr=5, fail_pat=1, fail_data=0x54;
   - done=1 at cycle 199 and fail_* unchanged by later mismatches.
4. Same fault with BIST_STOP_ON_FAIL_EN: fail=1 and done=1 both from cycle 57, busy=0, mem_ce=0 from cycle 57.
5. rst asserted in cycle 100 of a run -> all outputs 0 in cycle 101; a subsequent start gives a clean run with done 199 cycles later and fail=0.
6. start pulsed at cycles 20 and 60 during a run -> ignored, done still at cycle 199. start asserted in DONE after the fault run -> fail cleared the next cycle and WRITE restarts.

Source files
------------

// File: rtl/bist_march_ctrl.sv
// SRAM BIST march sequencer: per pattern, write all words, read them all back, then drain the compare pipeline.
// Optional macro BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module bist_march_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int NUM_PAT = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_pat,
  output logic [7:0]        fail_data,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [2:0]        LAST_PAT = 3'(NUM_PAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [2:0]        pat_idx;
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;
  logic              first_fail;
  logic              start_run;

  function automatic logic [7:0] pat_of(input logic [2:0] idx);
    case (idx)
      3'd0:    pat_of = 8'hAA;
      3'd1:    pat_of = 8'h55;
      3'd2:    pat_of = 8'hF0;
      3'd3:    pat_of = 8'h0F;
      3'd4:    pat_of = 8'h00;
      3'd5:    pat_of = 8'hFF;
      3'd6:    pat_of = 8'h00;
      default: pat_of = 8'hFF;
    endcase
  endfunction

  // Read data arrives one cycle after the read, while pat_idx still names the same pattern.
  assign mismatch   = cmp_vld && (mem_rdata != pat_of(pat_idx));
  assign first_fail = mismatch && !fail;
  assign start_run  = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_WRITE;
      S_WRITE: if (addr == ADDR_MAX) state_nxt = S_READ;
      S_READ:  if (addr == ADDR_MAX) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = (pat_idx == LAST_PAT) ? S_DONE : S_WRITE;
      S_DONE:  if (start) state_nxt = S_WRITE;
      default: state_nxt = S_IDLE;
    endcase
`ifdef BIST_STOP_ON_FAIL_EN
    if (first_fail) state_nxt = S_DONE;
`endif
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    case (state)
      S_WRITE: begin
        busy      = 1'b1;
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = pat_of(pat_idx);
      end
      S_READ: begin
        busy     = 1'b1;
        mem_ce   = 1'b1;
        mem_addr = addr;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      pat_idx   <= 3'd0;
      cmp_vld   <= 1'b0;
      cmp_addr  <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_pat  <= 3'd0;
      fail_data <= 8'h00;
    end else begin
      // A read issued while leaving for DONE early is dropped.
      cmp_vld  <= (state == S_READ) && ((state_nxt == S_READ) || (state_nxt == S_DRAIN));
      cmp_addr <= addr;
      if (start_run) begin
        addr      <= '0;
        pat_idx   <= 3'd0;
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_pat  <= 3'd0;
        fail_data <= 8'h00;
      end else begin
        case (state)
          S_WRITE, S_READ: addr <= addr + 1'b1;
          S_DRAIN: begin
            addr <= '0;
            if (state_nxt == S_WRITE) pat_idx <= pat_idx + 3'd1;
          end
          default: ;
        endcase
        if (first_fail) begin
          fail      <= 1'b1;
          fail_addr <= cmp_addr;
          fail_pat  <= pat_idx;
          fail_data <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Bench for bist_march_ctrl: checkpoint table for a clean run plus a cycle-by-cycle
// reference model driven by directed and random stuck-at faults in an SRAM model.
`timescale 1ns/1ps
module tb_bist_march_ctrl;
  localparam int ADDR_W   = 4;
  localparam int NUM_PAT  = 6;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int PAT_LEN  = 2 * DEPTH + 1;
  localparam int DONE_CYC = 1 + NUM_PAT * PAT_LEN;
`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  localparam logic [7:0] PAT [8] = '{8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h00, 8'hFF, 8'h00, 8'hFF};

  logic              clk, rst, start;
  logic              busy, done, fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_pat;
  logic [7:0]        fail_data;
  logic              mem_ce, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  bist_march_ctrl #(.ADDR_W(ADDR_W), .NUM_PAT(NUM_PAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_pat(fail_pat), .fail_data(fail_data),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with an optional stuck-at bit on one address, applied on read.
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;
  bit fault_en;
  int fault_addr, fault_bit;
  bit fault_val;

  function automatic logic [7:0] read_word(input logic [ADDR_W-1:0] a);
    logic [7:0] d;
    d = mem[a];
    if (fault_en && int'(a) == fault_addr) d[fault_bit] = fault_val;
    return d;
  endfunction

  always @(posedge clk) begin
    if (mem_ce && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_ce && !mem_we) rdata_q <= read_word(mem_addr);
  end
  assign mem_rdata = rdata_q;

  typedef struct packed {
    logic              busy, done, fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_pat;
    logic [7:0]        fail_data;
    logic              ce, we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  int n_pass = 0, n_total = 0;

  function automatic obs_t sample();
    obs_t o;
    o = '{busy: busy, done: done, fail: fail, fail_addr: fail_addr, fail_pat: fail_pat,
          fail_data: fail_data, ce: mem_ce, we: mem_we, addr: mem_addr, wdata: mem_wdata};
    return o;
  endfunction

  function automatic obs_t mk(input bit b, input bit d, input bit ce, input bit we,
                              input int a, input logic [7:0] w);
    obs_t o;
    o = '0;
    o.busy = b; o.done = d; o.ce = ce; o.we = we;
    o.addr = ADDR_W'(a); o.wdata = w;
    return o;
  endfunction

  task automatic check(input string name, input int cyc, input obs_t got, input obs_t exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h (busy,done,fail,faddr,fpat,fdata,ce,we,addr,wdata)",
                  name, cyc, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs from the march timing: each pattern is DEPTH writes, DEPTH reads, one drain.
  function automatic obs_t model(input int c, input int fail_cyc, input int done_cyc,
                                 input int fa, input int fp, input logic [7:0] fd);
    obs_t e;
    int k, p;
    e = '0;
    if (c >= done_cyc) e.done = 1'b1;
    else begin
      e.busy = 1'b1;
      k = (c - 1) % PAT_LEN;
      p = (c - 1) / PAT_LEN;
      if (k < DEPTH) begin
        e.ce = 1'b1; e.we = 1'b1; e.addr = ADDR_W'(k); e.wdata = PAT[p];
      end else if (k < 2 * DEPTH) begin
        e.ce = 1'b1; e.addr = ADDR_W'(k - DEPTH);
      end
    end
    if (fail_cyc >= 0 && c >= fail_cyc) begin
      e.fail = 1'b1; e.fail_addr = ADDR_W'(fa); e.fail_pat = 3'(fp); e.fail_data = fd;
    end
    return e;
  endfunction

  // Starts a run in the current cycle and checks every cycle until two past done.
  task automatic run_check(input bit fen, input int fa, input int fb, input bit fv, input bit pulses);
    int exp_fail, exp_done, exp_fp;
    logic [7:0] exp_fd, w;
    fault_en = fen; fault_addr = fa; fault_bit = fb; fault_val = fv;
    exp_fail = -1; exp_fp = 0; exp_fd = 8'h00;
    for (int p = 0; p < NUM_PAT; p++) begin
      w = PAT[p];
      if (fen && exp_fail < 0 && w[fb] != fv) begin
        exp_fail = 1 + p * PAT_LEN + DEPTH + fa + 2;
        exp_fp = p;
        exp_fd = w;
        exp_fd[fb] = fv;
      end
    end
    exp_done = (STOP && exp_fail >= 0) ? exp_fail : DONE_CYC;
    start = 1'b1;
    for (int c = 1; c <= exp_done + 2; c++) begin
      tick();
      start = pulses && (c == 20 || c == 60);
      check("run", c, sample(), model(c, exp_fail, exp_done, fa, exp_fp, exp_fd));
    end
    start = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    int idx;
    rst = 1'b1; start = 1'b0;
    fault_en = 1'b0; fault_addr = 0; fault_bit = 0; fault_val = 1'b0;

    tbl.push_back('{1,   mk(1, 0, 1, 1, 0,  8'hAA)});
    tbl.push_back('{16,  mk(1, 0, 1, 1, 15, 8'hAA)});
    tbl.push_back('{17,  mk(1, 0, 1, 0, 0,  8'h00)});
    tbl.push_back('{32,  mk(1, 0, 1, 0, 15, 8'h00)});
    tbl.push_back('{33,  mk(1, 0, 0, 0, 0,  8'h00)});
    tbl.push_back('{34,  mk(1, 0, 1, 1, 0,  8'h55)});
    tbl.push_back('{66,  mk(1, 0, 0, 0, 0,  8'h00)});
    tbl.push_back('{67,  mk(1, 0, 1, 1, 0,  8'hF0)});
    tbl.push_back('{100, mk(1, 0, 1, 1, 0,  8'h0F)});
    tbl.push_back('{133, mk(1, 0, 1, 1, 0,  8'h00)});
    tbl.push_back('{166, mk(1, 0, 1, 1, 0,  8'hFF)});
    tbl.push_back('{181, mk(1, 0, 1, 1, 15, 8'hFF)});
    tbl.push_back('{197, mk(1, 0, 1, 0, 15, 8'h00)});
    tbl.push_back('{198, mk(1, 0, 0, 0, 0,  8'h00)});
    tbl.push_back('{199, mk(0, 1, 0, 0, 0,  8'h00)});
    tbl.push_back('{205, mk(0, 1, 0, 0, 0,  8'h00)});

    // Reset, then idle with start low.
    tick(); tick();
    check("reset", 0, sample(), '0);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("idle", i, sample(), '0);
    end

    // Clean run against the checkpoint table.
    start = 1'b1;
    idx = 0;
    for (int c = 1; c <= 205; c++) begin
      tick();
      start = 1'b0;
      if (idx < tbl.size() && tbl[idx].cyc == c) begin
        check("clean_tbl", c, sample(), tbl[idx].exp);
        idx++;
      end
    end

    // Stuck-at-0 on bit 0 of address 5, started from DONE.
    run_check(1'b1, 5, 0, 1'b0, 1'b0);

    // Restart from DONE clears fail; start pulses mid-run are ignored.
    run_check(1'b0, 0, 0, 1'b0, 1'b1);

    // Reset in cycle 100 of a run.
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    check("mid_reset", 101, sample(), '0);
    rst = 1'b0;
    tick();
    run_check(1'b0, 0, 0, 1'b0, 1'b0);

    // Random single stuck-at faults.
    for (int r = 0; r < 6; r++)
      run_check(1'b1, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)),
                bit'($urandom_range(0, 1)), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
